// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost monitor.
//   state_t          : monitor FSM states (RUN until exit, then terminal)
//   TOHOST_PASS_CODE : tohost value that signals a passing exit
//   timeout_half()   : LED half-period used while in TIMEOUT
// The TIMEOUT fail_code is all-ones at whatever width fail_code has.
package tohost_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam int TOHOST_PASS_CODE = 1;

    // TIMEOUT blinks four times faster than FAIL, but never below one cycle.
    function automatic int timeout_half(input int blink_div);
        return (blink_div / 4 < 1) ? 1 : blink_div / 4;
    endfunction

endpackage

// File: rtl/tohost_monitor_blink_divider.sv
// Half-period divider for the status LED.
//   sysclk      : clock
//   rst         : asynchronous active-low reset
//   en          : count while high
//   clr         : restart the half-period (has priority over en)
//   half_period : cycles per LED half-period (>= 1)
//   toggle      : one-cycle pulse on the last cycle of each half-period
module tohost_monitor_blink_divider (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] half_period,
    output logic        toggle
);

    logic [31:0] cnt;
    logic        last;

    assign last   = (cnt == half_period - 32'd1);
    assign toggle = en && !clr && last;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + 32'd1;
    end

endmodule

// File: rtl/tohost_monitor.sv
// Snoops the data-memory store port for riscv-tests style writes to tohost and
// turns the exit status into sticky done/pass/fail_code plus a status LED.
//   sysclk, rst        : clock, asynchronous active-low reset
//   mem_wr_en/addr/... : store port being snooped (one cycle per store)
//   done, pass         : exit observed / exit was a pass
//   fail_code          : tohost>>1 on FAIL, all-ones on TIMEOUT, 0 otherwise
//   syscall_cnt        : even nonzero tohost writes seen, saturating at 255
//   led                : off in RUN, on in PASS, blinking in FAIL/TIMEOUT
// Optional: define TOHOST_TIMEOUT_EN to add a run-time watchdog that enters
// TIMEOUT after TIMEOUT_CYCLES cycles in RUN.
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter int TOHOST_ADDR    = 16384,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int BLINK_DIV      = 25000000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  mem_wr_en,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [3:0]            mem_be,
    output logic                  done,
    output logic                  pass,
    output logic [DATA_WIDTH-2:0] fail_code,
    output logic [7:0]            syscall_cnt,
    output logic                  led
);

    localparam logic [ADDR_WIDTH-1:0] TOHOST_A = ADDR_WIDTH'(TOHOST_ADDR);

    state_t      state_q, state_d;
    logic        hit, entry, tmo_expire, blink_toggle;
    logic [31:0] half_period;

    // Only full-word stores to the tohost word count; byte offset is ignored.
    assign hit = mem_wr_en && (mem_be == 4'hF) &&
                 (mem_addr[ADDR_WIDTH-1:2] == TOHOST_A[ADDR_WIDTH-1:2]);

`ifdef TOHOST_TIMEOUT_EN
    logic [31:0] tmr;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst)
            tmr <= '0;
        else if (state_q == ST_RUN)
            tmr <= tmr + 32'd1;
    end

    assign tmo_expire = (state_q == ST_RUN) && (tmr == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
    assign tmo_expire = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^mem_addr[1:0];

    // State register
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Next state: an exit store beats a coincident watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (hit && mem_wdata == DATA_WIDTH'(TOHOST_PASS_CODE))
                    state_d = ST_PASS;
                else if (hit && mem_wdata[0])
                    state_d = ST_FAIL;
                else if (tmo_expire)
                    state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        done = (state_q != ST_RUN);
        pass = (state_q == ST_PASS);
    end

    assign entry = (state_q == ST_RUN) && (state_d != ST_RUN);

    assign half_period = (state_q == ST_TIMEOUT) ? 32'(timeout_half(BLINK_DIV))
                                                 : 32'(BLINK_DIV);

    tohost_monitor_blink_divider u_blink (
        .sysclk      (sysclk),
        .rst         (rst),
        .en          ((state_q == ST_FAIL) || (state_q == ST_TIMEOUT)),
        .clr         (entry),
        .half_period (half_period),
        .toggle      (blink_toggle)
    );

    // Data registers only move while in RUN (or on the way out of it).
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            fail_code   <= '0;
            syscall_cnt <= '0;
            led         <= 1'b0;
        end else begin
            if (state_q == ST_RUN) begin
                if (state_d == ST_FAIL)
                    fail_code <= mem_wdata[DATA_WIDTH-1:1];
                else if (state_d == ST_TIMEOUT)
                    fail_code <= '1;
                if (hit && !mem_wdata[0] && (mem_wdata != '0) && (syscall_cnt != 8'hFF))
                    syscall_cnt <= syscall_cnt + 8'd1;
            end
            // Every terminal state lights the LED on entry; blinking starts from there.
            if (entry)
                led <= 1'b1;
            else if (blink_toggle)
                led <= ~led;
        end
    end

endmodule
